// File: rtl/freq_result_calc.sv
`default_nettype none
// ============================================================================
// freq_result_calc: runs one period measurement, picks the finest in-range
// channel count and divides it into a frequency result. Rev 1.0
// ============================================================================
module freq_result_calc #(
  parameter int unsigned   NCH       = 10,
  parameter int unsigned   CW        = 32,
  parameter logic [63:0]   BASE_HZ   = 64'd100_000_000,
  parameter logic [63:0]   SCALE     = 64'd1,
  parameter logic [CW-1:0] MIN_COUNT = 16,
  parameter logic [CW-1:0] MAX_COUNT = 32'hFFFF_FFF0,
  parameter int unsigned   TIMEOUT   = 100_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic                    meas_busy_i,
  input  logic [NCH-1:0][CW-1:0]  val_i,
  output logic                    meas_start_o,
  output logic                    busy_o,
  output logic                    result_valid_o,
  output logic [31:0]             freq_o,
  output logic [3:0]              chan_o,
  output logic [1:0]              err_o
);

  localparam int unsigned IW   = $clog2(NCH + 1);
  localparam logic [63:0] PROD = BASE_HZ * SCALE;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO, S_CAPTURE, S_SELECT, S_DIVIDE, S_DONE
  } state_t;

  state_t                 state_q;
  logic                   meas_start_q, busy_q, rv_q;
  logic [31:0]            freq_q;
  logic [3:0]             chan_q;
  logic [1:0]             err_q;
  logic [31:0]            tcnt_q;
  logic [NCH-1:0][CW-1:0] cap_q;
  logic [IW-1:0]          idx_q, sel_q;
  logic                   found_q;
  logic [63:0]            rem_q, quo_q, div_q;
  logic [5:0]             dcnt_q;

  logic [CW-1:0] cur_cnt, sel_cnt;
  logic          cur_ok, found_d, ge;
  logic [IW-1:0] sel_d;
  logic [63:0]   num_d, rem_d, quo_d;
  logic [64:0]   trial;

  always_comb begin
    cur_cnt = '0;
    sel_cnt = '0;
    if (idx_q < IW'(NCH)) cur_cnt = cap_q[idx_q];
    cur_ok  = (cur_cnt >= MIN_COUNT) && (cur_cnt <= MAX_COUNT) && (idx_q < IW'(NCH));
    found_d = found_q | cur_ok;
    sel_d   = found_q ? sel_q : idx_q;
    if (sel_d < IW'(NCH)) sel_cnt = cap_q[sel_d];
    num_d   = PROD >> sel_d;
    // One restoring step: the remainder stays below the divisor, so 65 bits suffice.
    trial   = {rem_q, quo_q[63]};
    ge      = trial >= {1'b0, div_q};
    rem_d   = ge ? 64'(trial - {1'b0, div_q}) : trial[63:0];
    quo_d   = {quo_q[62:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      meas_start_q <= 1'b0;
      busy_q       <= 1'b0;
      rv_q         <= 1'b0;
      freq_q       <= '0;
      chan_q       <= '0;
      err_q        <= '0;
      tcnt_q       <= '0;
      cap_q        <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      found_q      <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_q        <= '0;
      dcnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            state_q      <= S_START;
            meas_start_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_START: begin
          meas_start_q <= 1'b0;
          tcnt_q       <= '0;
          state_q      <= S_WAIT_HI;
        end
        S_WAIT_HI, S_WAIT_LO: begin
          tcnt_q <= tcnt_q + 1;
          if (tcnt_q == TIMEOUT - 1) begin
            state_q <= S_DONE;
            rv_q    <= 1'b1;
            freq_q  <= '0;
            chan_q  <= '0;
            err_q   <= 2'd2;
          end else if (state_q == S_WAIT_HI && meas_busy_i) begin
            state_q <= S_WAIT_LO;
          end else if (state_q == S_WAIT_LO && !meas_busy_i) begin
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          cap_q   <= val_i;
          idx_q   <= '0;
          sel_q   <= '0;
          found_q <= 1'b0;
          state_q <= S_SELECT;
        end
        S_SELECT: begin
          idx_q   <= idx_q + 1'b1;
          found_q <= found_d;
          sel_q   <= sel_d;
          // A miss spends one extra resolve cycle (idx == NCH) before reporting.
          if (idx_q == IW'(NCH - 1) && found_d) begin
            quo_q   <= num_d;
            rem_q   <= '0;
            div_q   <= {{(64-CW){1'b0}}, sel_cnt};
            dcnt_q  <= '0;
            state_q <= S_DIVIDE;
          end else if (idx_q == IW'(NCH)) begin
            state_q <= S_DONE;
            rv_q    <= 1'b1;
            freq_q  <= '0;
            chan_q  <= '0;
            err_q   <= 2'd1;
          end
        end
        S_DIVIDE: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          dcnt_q <= dcnt_q + 1'b1;
          if (dcnt_q == 6'd63) begin
            state_q <= S_DONE;
            rv_q    <= 1'b1;
            freq_q  <= (quo_d[63:32] != 32'd0) ? 32'hFFFF_FFFF : quo_d[31:0];
            chan_q  <= 4'(sel_q);
            err_q   <= 2'd0;
          end
        end
        S_DONE: begin
          rv_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign meas_start_o   = meas_start_q;
  assign busy_o         = busy_q;
  assign result_valid_o = rv_q;
  assign freq_o         = freq_q;
  assign chan_o         = chan_q;
  assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_result_calc.sv
`default_nettype none
// ============================================================================
// tb_freq_result_calc: directed and random conversions on two parameterisations
// (SCALE=1 and SCALE=1e9) checked against an arithmetic reference. Rev 1.0
// ============================================================================
module tb_freq_result_calc;

  localparam int          NCH     = 10;
  localparam int          TO      = 50;
  localparam logic [63:0] SCALE_A = 64'd1;
  localparam logic [63:0] SCALE_B = 64'd1_000_000_000;

  typedef logic [NCH-1:0][31:0] vec_t;

  logic        clk, rst_n, req, meas_busy;
  vec_t        val;
  logic        ms_a, busy_a, rv_a, ms_b, busy_b, rv_b;
  logic [31:0] freq_a, freq_b;
  logic [3:0]  chan_a, chan_b;
  logic [1:0]  err_a, err_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  freq_result_calc #(.TIMEOUT(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .meas_busy_i(meas_busy), .val_i(val),
    .meas_start_o(ms_a), .busy_o(busy_a), .result_valid_o(rv_a),
    .freq_o(freq_a), .chan_o(chan_a), .err_o(err_a)
  );

  freq_result_calc #(.SCALE(SCALE_B), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req), .meas_busy_i(meas_busy), .val_i(val),
    .meas_start_o(ms_b), .busy_o(busy_b), .result_valid_o(rv_b),
    .freq_o(freq_b), .chan_o(chan_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First in-range channel wins; frequency is floor((BASE*SCALE >> i) / count), saturated.
  function automatic void model(input vec_t v, input logic [63:0] sc,
                                output logic [31:0] f, output logic [3:0] c, output logic [1:0] e);
    logic [63:0] q;
    f = 32'd0; c = 4'd0; e = 2'd1;
    for (int i = 0; i < NCH; i++) begin
      if (v[i] >= 32'd16 && v[i] <= 32'hFFFF_FFF0) begin
        q = ((64'd100_000_000 * sc) >> i) / {32'd0, v[i]};
        f = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
        c = 4'(i);
        e = 2'd0;
        break;
      end
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ":ms"},   ms_a,   0);
    check({tag, ":busy"}, busy_a, 0);
    check({tag, ":rv"},   rv_a,   0);
    check({tag, ":freq"}, freq_a, 0);
    check({tag, ":chan"}, chan_a, 0);
    check({tag, ":err"},  err_a,  0);
    check({tag, ":rv_b"}, rv_b,   0);
    check({tag, ":fr_b"}, freq_b, 0);
  endtask

  // Entered and left on a negedge with the DUTs idle; blen<0 holds meas_busy high.
  task automatic conv(input vec_t v, input int blen, input int abort_at, input string tag);
    logic [31:0] fa, fb;
    logic [3:0]  ca, cb;
    logic [1:0]  ea, eb;
    int          s, u, expc;
    bit          seen;
    model(v, SCALE_A, fa, ca, ea);
    model(v, SCALE_B, fb, cb, eb);
    val = v; req = 1'b1; meas_busy = 1'b0;
    @(negedge clk);
    req = 1'b0;
    check({tag, ":start"}, ms_a, 1);
    check({tag, ":busy_on"}, busy_a, 1);
    s = cyc;
    @(negedge clk);
    check({tag, ":start_1cyc"}, ms_a, 0);
    meas_busy = 1'b1;
    if (blen < 0) begin
      fa = 0; fb = 0; ca = 0; cb = 0; ea = 2'd2; eb = 2'd2;
      expc = s + TO + 1;
    end else begin
      repeat (blen) @(negedge clk);
      meas_busy = 1'b0;
      u = cyc;
      @(negedge clk);
      @(negedge clk);
      val = ~v;
      expc = (ea == 2'd1) ? u + 3 + NCH : u + 2 + NCH + 64;
    end
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_vals({tag, ":abort"});
      seen = 0;
      repeat (120) begin
        @(negedge clk);
        if (rv_a || rv_b || busy_a) seen = 1;
      end
      check({tag, ":no_stale"}, seen, 0);
      return;
    end
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (rv_a) seen = 1;
    end
    check({tag, ":rv_seen"}, seen, 1);
    check({tag, ":rv_cycle"}, cyc, expc);
    check({tag, ":rv_b"}, rv_b, 1);
    check({tag, ":freq_a"}, freq_a, fa);
    check({tag, ":chan_a"}, chan_a, ca);
    check({tag, ":err_a"}, err_a, ea);
    check({tag, ":freq_b"}, freq_b, fb);
    check({tag, ":chan_b"}, chan_b, cb);
    check({tag, ":err_b"}, err_b, eb);
    @(negedge clk);
    meas_busy = 1'b0;
    check({tag, ":rv_pulse"}, rv_a, 0);
    check({tag, ":busy_off"}, busy_a, 0);
    check({tag, ":freq_hold"}, freq_a, fa);
  endtask

  initial begin
    vec_t v;
    int   kind;
    rst_n = 1'b0; req = 1'b0; meas_busy = 1'b0; val = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    v = '0; v[0] = 32'd1000;
    conv(v, 5, -1, "basic");
    v = '0; v[0] = 32'hFFFF_FFFF; v[1] = 32'd500_000;
    conv(v, 3, -1, "ch1");
    v = '0;
    conv(v, 4, -1, "none");
    v = '0; v[0] = 32'd1000;
    conv(v, -1, -1, "timeout");
    v = '0; v[0] = 32'd16;
    conv(v, 2, -1, "sat");
    v = '0; v[0] = 32'd1000;
    conv(v, 6, 30, "abort");
    v = '0; v[2] = 32'd250;
    conv(v, 5, -1, "after_abort");
    v = '0; v[0] = 32'd15; v[1] = 32'hFFFF_FFF1; v[2] = 32'hFFFF_FFF0;
    conv(v, 1, -1, "bounds");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NCH; i++) begin
        kind = int'($urandom_range(0, 3));
        case (kind)
          0:       v[i] = $urandom_range(0, 15);
          1:       v[i] = $urandom_range(16, 2_000_000);
          2:       v[i] = $urandom;
          default: v[i] = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        endcase
      end
      conv(v, int'($urandom_range(1, 20)), -1, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
